// File: rtl/mdu_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master drives the operation request and cancel; the slave returns status and results.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Define MDU_DIV_EN to build the divider; without it divu/div complete at once with no result.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic             neg_lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // op[0] marks the signed variants (mult, div)
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = bus.op[0] & bus.a[WIDTH-1];
    b_neg = bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // Multiplier in acc_lo shifts out LSB-first while the partial product grows into acc_hi
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;

`ifdef MDU_DIV_EN
  logic             neg_hi_reg;
  logic             zdiv_reg;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // Restoring division: remainder in acc_hi, dividend bits leave acc_lo MSB-first
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
    if (op_reg[1]) begin
      if (!div_diff[WIDTH+1]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end
    q_res = neg_lo_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
    r_res = neg_hi_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
`endif
    prod_mag = {acc_hi_reg, acc_lo_reg};
    prod_res = neg_lo_reg ? (~prod_mag + 1'b1) : prod_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      neg_lo_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef MDU_DIV_EN
      neg_hi_reg <= 1'b0;
      zdiv_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // cancel takes priority over a simultaneous start
          if (bus.start && !bus.cancel) begin
            op_reg     <= bus.op;
            cnt_reg    <= '0;
            dbz_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            acc_hi_reg <= '0;
            neg_lo_reg <= a_neg ^ b_neg;
            if (bus.op[1]) begin
              acc_lo_reg <= a_mag;
              opnd_reg   <= b_mag;
`ifdef MDU_DIV_EN
              neg_hi_reg <= a_neg;
              zdiv_reg   <= (bus.b == '0);
              state_reg  <= CALC;
`else
              state_reg  <= ADJ;
`endif
            end else begin
              acc_lo_reg <= b_mag;
              opnd_reg   <= a_mag;
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
              state_reg <= ADJ;
            end
          end
        end
        ADJ: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!bus.cancel) begin
            done_reg <= 1'b1;
            if (!op_reg[1]) begin
              hi_reg <= prod_res[2*WIDTH-1:WIDTH];
              lo_reg <= prod_res[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            else begin
              // a zero divisor leaves the dividend in the remainder and all-ones quotient
              hi_reg  <= r_res;
              lo_reg  <= zdiv_reg ? {WIDTH{1'b1}} : q_res;
              dbz_reg <= zdiv_reg;
            end
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; all values below assume 32.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request; accepted only when state is IDLE.
REQ-005 op  in  2  00 multu, 01 mult, 10 divu, 11 div; sampled with start.
REQ-006 a  in  32  multiplicand or dividend; sampled with start.
REQ-007 b  in  32  multiplier or divisor; sampled with start.
REQ-008 cancel  in  1  abort of the in-flight operation.
REQ-009 busy  out  1  high in CALC and ADJ states.
REQ-010 done  out  1  registered one-cycle pulse when hi/lo are updated.
REQ-011 hi  out  32  product[63:32] or remainder.
REQ-012 lo  out  32  product[31:0] or quotient.
REQ-013 div_by_zero  out  1  set with done for a divide with b=0; held until the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and ADJ; transitions are IDLE->CALC on accepted start, CALC->ADJ after 32 iterations, and ADJ->IDLE.
REQ-015 Acceptance edge E0 SHALL latch op/a/b, convert signed operands to magnitudes and clear div_by_zero; edges E1..E32 SHALL each perform one shift-add or restoring-subtract step using a 6-bit iteration counter.
REQ-016 Edge E33 (ADJ) SHALL apply sign correction, write hi/lo and set done=1 for exactly one cycle; busy SHALL fall at the same edge.
REQ-017 Multiply results SHALL be the full 64-bit product {hi,lo}: unsigned for multu, two's-complement for mult.
REQ-018 divu SHALL produce lo=floor(a/b) and hi=a mod b.
REQ-019 div SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-020 For div 0x80000000 / 0xFFFFFFFF the block SHALL produce lo=0x80000000 and hi=0 with no flag.
REQ-021 For a divide with b=0, the operation SHALL still take 33 cycles and produce hi=a, lo=0xFFFFFFFF and div_by_zero=1.
REQ-022 A start in the cycle done is high SHALL be accepted (back-to-back, no bubble); start while busy SHALL be ignored.
REQ-023 cancel while busy SHALL force IDLE at the next edge with no done and hi/lo unchanged.
REQ-024 cancel with start in IDLE SHALL win, and the start SHALL be dropped.
REQ-025 hi and lo SHALL change only at an ADJ edge or on reset.

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear the counter and internal registers.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse after release.
REQ-028 The first start SHALL be accepted at the first rising edge after rst_n rises.

Configuration
REQ-029 Macro MDU_DIV_EN defined SHALL enable divu/div as specified, including the divider datapath.
REQ-030 Without MDU_DIV_EN, the divider datapath SHALL be absent; an accepted op 10/11 SHALL go IDLE->ADJ with done at E1, hi/lo unchanged and div_by_zero=0, while multiply ops are unaffected.

Verification
REQ-031 multu a=0xFFFFFFFF b=0xFFFFFFFF -> after E33 hi=0xFFFFFFFE, lo=0x00000001, done high one cycle, busy low.
REQ-032 mult a=0xFFFFFFFE b=0x00000003, issued back-to-back in the done cycle of REQ-031 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA 33 cycles later.
REQ-033 div a=0xFFFFFFF9 b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 divu a=0x00000064 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1; the next start clears the flag.
REQ-035 cancel at E10 of a multu, then rst_n pulsed low mid-way through a second op -> no done pulse for either; hi/lo hold prior values, then read 0 after reset.
REQ-036 Build without MDU_DIV_EN, divu 9/2 -> done at E1, hi/lo unchanged; multu 3*5 -> lo=0x0000000F at E33.
